dnpcie_aurora_rx_frame_buffer: RTL and testbench

- Sits directly downstream of the per-lane Aurora core's CRC-checked 32-bit receive output. That output has no backpressure.
- Stores frames in a store-and-forward buffer. Commits a frame only when its CRC passes and it has no length error; rewinds and discards failed or overflowed frames.
- Presents committed frames on a tready-flow-controlled AXI4-Stream master.
- Generates the native-flow-control XOFF request that feeds back to the core's s_axis_tx_nfc_xoff so the far end pauses before the buffer overflows.

---
 rtl/dnpcie_aurora_rx_frame_buffer.sv | 150 +++++++++++++++
 tb/tb_dnpcie_aurora_rx_frame_buffer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dnpcie_aurora_rx_frame_buffer.sv
// Store-and-forward receive buffer behind the Aurora CRC checker: commits good frames, rewinds
// bad or overflowed ones, and raises NFC XOFF with hysteresis on buffer occupancy.
module dnpcie_aurora_rx_frame_buffer #(
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned XOFF_THRESH = 128,
  parameter int unsigned XON_THRESH  = 256
) (
  input  logic          aclk,
  input  logic          reset,
  input  logic [0:31]   s_axis_tdata,
  input  logic [0:3]    s_axis_tkeep,
  input  logic          s_axis_tvalid,
  input  logic          s_axis_tlast,
  input  logic          s_axis_crc_valid,
  input  logic          s_axis_crc_pass_fail_n,
  input  logic          s_axis_length_err,
  output logic [0:31]   m_axis_tdata,
  output logic [0:3]    m_axis_tkeep,
  output logic          m_axis_tvalid,
  output logic          m_axis_tlast,
  input  logic          m_axis_tready,
  output logic          nfc_xoff,
  output logic [15:0]   frames_ok,
  output logic [15:0]   frames_bad,
  output logic [15:0]   frames_ovf,
  output logic          overflow
);

  localparam int unsigned     DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_V = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] XOFF_V  = XOFF_THRESH[ADDR_W:0];
  localparam logic [ADDR_W:0] XON_V   = XON_THRESH[ADDR_W:0];

  logic [36:0]     r_mem [DEPTH];
  logic [ADDR_W:0] r_wr_ptr;
  logic [ADDR_W:0] r_commit_ptr;
  logic [ADDR_W:0] r_rd_ptr;
  logic            r_drop;
  logic            r_m_valid;
  logic [0:31]     r_m_data;
  logic [0:3]      r_m_keep;
  logic            r_m_last;
  logic            r_xoff;
  logic            r_ovf;
  logic [15:0]     r_frames_ok;
  logic [15:0]     r_frames_bad;
  logic [15:0]     r_frames_ovf;

  logic [ADDR_W:0] w_used;
  logic [ADDR_W:0] w_free;
  logic            w_full;
  logic            w_readable;
  logic            w_wr_en;
  logic            w_eop;
  logic            w_frame_ok;
  logic            w_load;
  logic [36:0]     w_rd_word;

  assign w_used     = r_wr_ptr - r_rd_ptr;
  assign w_free     = DEPTH_V - w_used;
  assign w_full     = (w_used == DEPTH_V);
  assign w_readable = (r_rd_ptr != r_commit_ptr);
  assign w_wr_en    = s_axis_tvalid && !r_drop && !w_full;
  assign w_eop      = s_axis_tvalid && s_axis_tlast;
  assign w_frame_ok = s_axis_crc_valid && s_axis_crc_pass_fail_n && !s_axis_length_err;
  assign w_load     = w_readable && (!r_m_valid || m_axis_tready);
  assign w_rd_word  = r_mem[r_rd_ptr[ADDR_W-1:0]];

  always_ff @(posedge aclk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr[ADDR_W-1:0]] <= {s_axis_tdata, s_axis_tkeep, s_axis_tlast};
    end
  end

  // End of frame: overflow beats CRC status; a rewind only ever moves wr_ptr back to commit_ptr.
  always_ff @(posedge aclk) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_commit_ptr <= '0;
      r_drop       <= 1'b0;
      r_ovf        <= 1'b0;
      r_frames_ok  <= '0;
      r_frames_bad <= '0;
      r_frames_ovf <= '0;
    end else begin
      r_ovf <= 1'b0;
      if (w_eop) begin
        if (r_drop || w_full) begin
          r_wr_ptr <= r_commit_ptr;
          r_drop   <= 1'b0;
          r_ovf    <= 1'b1;
          if (r_frames_ovf != 16'hFFFF) r_frames_ovf <= r_frames_ovf + 16'd1;
        end else if (w_frame_ok) begin
          r_wr_ptr     <= r_wr_ptr + PTR_ONE;
          r_commit_ptr <= r_wr_ptr + PTR_ONE;
          if (r_frames_ok != 16'hFFFF) r_frames_ok <= r_frames_ok + 16'd1;
        end else begin
          r_wr_ptr <= r_commit_ptr;
          if (r_frames_bad != 16'hFFFF) r_frames_bad <= r_frames_bad + 16'd1;
        end
      end else if (s_axis_tvalid) begin
        if (r_drop || w_full) begin
          r_drop <= 1'b1;
        end else begin
          r_wr_ptr <= r_wr_ptr + PTR_ONE;
        end
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      r_rd_ptr  <= '0;
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_keep  <= '0;
      r_m_last  <= 1'b0;
    end else if (w_load) begin
      r_rd_ptr  <= r_rd_ptr + PTR_ONE;
      r_m_valid <= 1'b1;
      r_m_data  <= w_rd_word[36:5];
      r_m_keep  <= w_rd_word[4:1];
      r_m_last  <= w_rd_word[0];
    end else if (m_axis_tready) begin
      r_m_valid <= 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      r_xoff <= 1'b0;
    end else if (w_free < XOFF_V) begin
      r_xoff <= 1'b1;
    end else if (w_free >= XON_V) begin
      r_xoff <= 1'b0;
    end
  end

  assign m_axis_tdata  = r_m_data;
  assign m_axis_tkeep  = r_m_keep;
  assign m_axis_tvalid = r_m_valid;
  assign m_axis_tlast  = r_m_last;
  assign nfc_xoff      = r_xoff;
  assign frames_ok     = r_frames_ok;
  assign frames_bad    = r_frames_bad;
  assign frames_ovf    = r_frames_ovf;
  assign overflow      = r_ovf;

endmodule

// File: tb/tb_dnpcie_aurora_rx_frame_buffer.sv
// Bench for the Aurora RX frame buffer: queue-based occupancy model checked every cycle, plus
// directed frame scenarios with literal expectations.
module tb_dnpcie_aurora_rx_frame_buffer;

  logic        aclk = 1'b0;
  logic        reset = 1'b0;
  logic [0:31] s_tdata = '0;
  logic [0:3]  s_tkeep = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tlast = 1'b0;
  logic        s_crcv = 1'b0;
  logic        s_pass = 1'b0;
  logic        s_lerr = 1'b0;
  logic [0:31] m_tdata;
  logic [0:3]  m_tkeep;
  logic        m_tvalid;
  logic        m_tlast;
  logic        m_tready = 1'b0;
  logic        nfc_xoff;
  logic [15:0] frames_ok;
  logic [15:0] frames_bad;
  logic [15:0] frames_ovf;
  logic        overflow;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  dnpcie_aurora_rx_frame_buffer dut (
    .aclk                   (aclk),
    .reset                  (reset),
    .s_axis_tdata           (s_tdata),
    .s_axis_tkeep           (s_tkeep),
    .s_axis_tvalid          (s_tvalid),
    .s_axis_tlast           (s_tlast),
    .s_axis_crc_valid       (s_crcv),
    .s_axis_crc_pass_fail_n (s_pass),
    .s_axis_length_err      (s_lerr),
    .m_axis_tdata           (m_tdata),
    .m_axis_tkeep           (m_tkeep),
    .m_axis_tvalid          (m_tvalid),
    .m_axis_tlast           (m_tlast),
    .m_axis_tready          (m_tready),
    .nfc_xoff               (nfc_xoff),
    .frames_ok              (frames_ok),
    .frames_bad             (frames_bad),
    .frames_ovf             (frames_ovf),
    .overflow               (overflow)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a 512-entry store holding the frame in progress plus committed-but-unread beats,
  // with a single output slot pulled from the committed queue.
  logic [36:0] md_pend[$];
  logic [36:0] md_comm[$];
  bit          md_valid = 1'b0;
  logic [36:0] md_beat = '0;
  bit          md_drop = 1'b0;
  bit          md_xoff = 1'b0;
  bit          md_ovf = 1'b0;
  logic [15:0] md_ok = '0;
  logic [15:0] md_bad = '0;
  logic [15:0] md_ovfc = '0;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always @(posedge aclk) begin
    int used;
    bit full;
    if (reset) begin
      md_pend.delete(); md_comm.delete();
      md_valid = 0; md_beat = '0; md_drop = 0; md_xoff = 0; md_ovf = 0;
      md_ok = '0; md_bad = '0; md_ovfc = '0;
    end else begin
      used = md_pend.size() + md_comm.size();
      full = (used == 512);
      if (md_valid && m_tready) md_valid = 0;
      if (!md_valid && md_comm.size() > 0) begin
        md_beat = md_comm.pop_front();
        md_valid = 1;
      end
      md_ovf = 0;
      if (s_tvalid) begin
        if (!md_drop && !full) md_pend.push_back({s_tdata, s_tkeep, s_tlast});
        if (s_tlast) begin
          if (md_drop || full) begin
            md_ovfc = sat_inc(md_ovfc); md_ovf = 1; md_drop = 0;
          end else if (s_crcv && s_pass && !s_lerr) begin
            foreach (md_pend[k]) md_comm.push_back(md_pend[k]);
            md_ok = sat_inc(md_ok);
          end else begin
            md_bad = sat_inc(md_bad);
          end
          md_pend.delete();
        end else if (full) begin
          md_drop = 1;
        end
      end
      if (512 - used < 128) md_xoff = 1;
      else if (512 - used >= 256) md_xoff = 0;
    end
  end

  logic [36:0] got[$];
  int          ovf_pulses = 0;
  bit          prev_stall = 0;
  logic [36:0] prev_beat = '0;

  always @(negedge aclk) begin
    if (chk_en) begin
      chk("tvalid", m_tvalid, md_valid);
      if (md_valid) chk("beat", {m_tdata, m_tkeep, m_tlast}, md_beat);
      chk("nfc_xoff", nfc_xoff, md_xoff);
      chk("overflow", overflow, md_ovf);
      chk("frames_ok", frames_ok, md_ok);
      chk("frames_bad", frames_bad, md_bad);
      chk("frames_ovf", frames_ovf, md_ovfc);
      if (reset) begin
        prev_stall = 0;
      end else begin
        if (prev_stall) begin
          chk("hold_valid", m_tvalid, 1'b1);
          chk("hold_beat", {m_tdata, m_tkeep, m_tlast}, prev_beat);
        end
        prev_stall = m_tvalid && !m_tready;
        prev_beat = {m_tdata, m_tkeep, m_tlast};
        if (m_tvalid && m_tready) got.push_back({m_tdata, m_tkeep, m_tlast});
        if (overflow) ovf_pulses++;
      end
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic idle_inputs();
    s_tvalid = 0; s_tlast = 0; s_crcv = 0; s_pass = 0; s_lerr = 0;
    s_tdata = '0; s_tkeep = '0;
  endtask

  task automatic do_reset();
    reset = 1;
    idle_inputs();
    tick();
    chk_en = 1;
    tick();
    reset = 0;
    got.delete();
    ovf_pulses = 0;
  endtask

  task automatic drive_beat(input logic [31:0] d, input logic last, input logic pass,
                            input logic lerr);
    s_tvalid = 1; s_tdata = d; s_tkeep = last ? 4'h3 : 4'hF; s_tlast = last;
    s_crcv = last; s_pass = last & pass; s_lerr = last & lerr;
  endtask

  task automatic send_frame(input int n, input logic [31:0] base, input logic pass,
                            input logic lerr);
    for (int i = 0; i < n; i++) begin
      drive_beat(base + 32'(i), (i == n - 1), pass, lerr);
      tick();
    end
    idle_inputs();
  endtask

  task automatic wait_got(input string name, input int n, input int budget);
    int c = 0;
    while (got.size() < n && c < budget) begin
      tick();
      c++;
    end
    chk(name, got.size(), n);
  endtask

  initial begin
    int lat;
    #20_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    // 4-beat good frame, latency and content
    do_reset();
    m_tready = 1;
    send_frame(4, 32'h1, 1, 0);
    lat = 0;
    while (!m_tvalid && lat < 6) begin
      @(posedge aclk); lat++; @(negedge aclk);
    end
    chk("t1_latency_le2", (lat >= 1 && lat <= 2), 1'b1);
    wait_got("t1_count", 4, 20);
    tick(); tick();
    for (int i = 0; i < 4; i++) chk("t1_data", got[i][36:5], 32'(i + 1));
    chk("t1_last", {got[0][0], got[1][0], got[2][0], got[3][0]}, 4'b0001);
    chk("t1_keep_last", got[3][4:1], 4'h3);
    chk("t1_frames_ok", frames_ok, 16'd1);

    // CRC-failed frame then good 2-beat frame
    do_reset();
    m_tready = 1;
    send_frame(4, 32'h1, 0, 0);
    send_frame(2, 32'h10, 1, 0);
    repeat (8) tick();
    chk("t2_count", got.size(), 2);
    chk("t2_d0", got[0][36:5], 32'h10);
    chk("t2_d1", got[1][36:5], 32'h11);
    chk("t2_bad", frames_bad, 16'd1);
    chk("t2_ok", frames_ok, 16'd1);

    // overflow with tready low, then drain
    do_reset();
    m_tready = 0;
    for (int f = 0; f < 6; f++) send_frame(100, 32'h10000 * (f + 1), 1, 0);
    tick(); tick();
    chk("t3_ok", frames_ok, 16'd5);
    chk("t3_ovf", frames_ovf, 16'd1);
    chk("t3_ovf_pulses", ovf_pulses, 1);
    chk("t3_xoff_on", nfc_xoff, 1'b1);
    m_tready = 1;
    wait_got("t3_drain", 500, 700);
    repeat (4) tick();
    chk("t3_count", got.size(), 500);
    chk("t3_first", got[0][36:5], 32'h10000);
    chk("t3_last_d", got[499][36:5], 32'h50000 + 32'd99);
    chk("t3_last_l", got[499][0], 1'b1);
    chk("t3_xoff_off", nfc_xoff, 1'b0);

    // tready toggling every cycle
    do_reset();
    m_tready = 1;
    for (int i = 0; i < 10; i++) begin
      drive_beat(32'hA0 + 32'(i), (i == 9), 1, 0);
      m_tready = ~m_tready;
      tick();
    end
    idle_inputs();
    for (int i = 0; i < 40; i++) begin
      m_tready = ~m_tready;
      tick();
    end
    chk("t4_count", got.size(), 10);
    for (int i = 0; i < 10; i++) chk("t4_order", got[i][36:5], 32'hA0 + 32'(i));

    // reset mid-frame with committed frames unread
    do_reset();
    m_tready = 0;
    send_frame(3, 32'h100, 1, 0);
    send_frame(3, 32'h200, 1, 0);
    drive_beat(32'h300, 0, 1, 0); tick();
    drive_beat(32'h301, 0, 1, 0); tick();
    drive_beat(32'h302, 0, 1, 0);
    reset = 1;
    tick();
    reset = 0;
    idle_inputs();
    got.delete();
    @(negedge aclk);
    chk("t5_tvalid", m_tvalid, 1'b0);
    chk("t5_tdata", m_tdata, 32'h0);
    chk("t5_cnts", {frames_ok, frames_bad, frames_ovf}, 48'h0);
    #1;
    m_tready = 1;
    send_frame(2, 32'h400, 1, 0);
    repeat (6) tick();
    chk("t5_count", got.size(), 2);
    chk("t5_d0", got[0][36:5], 32'h400);
    chk("t5_d1", got[1][36:5], 32'h401);

    // single-beat frames: length error, then good
    do_reset();
    m_tready = 1;
    send_frame(1, 32'hBAD, 1, 1);
    send_frame(1, 32'h600D, 1, 0);
    repeat (6) tick();
    chk("t6_bad", frames_bad, 16'd1);
    chk("t6_ok", frames_ok, 16'd1);
    chk("t6_count", got.size(), 1);
    chk("t6_data", got[0][36:5], 32'h600D);
    chk("t6_last", got[0][0], 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
